// File: rtl/squeeze_datapath.sv
// Output stage of the sponge: serialises a captured rate block into byte-swapped w-bit
// words, truncates to the requested length and asks for more permutations when needed.
module squeeze_datapath #(
  parameter int w          = 64,
  parameter int RATE_WIDTH = 1344
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            operation_mode_i,
  input  logic [31:0]           output_size_i,
  input  logic [RATE_WIDTH-1:0] rate_input_i,
  input  logic                  rate_valid_i,
  output logic                  rate_ready_o,
  output logic                  squeeze_req_o,
  output logic [w-1:0]          data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  done_o
);

  localparam logic [1:0]  SHAKE128_MODE_VEC = 2'b00;
  localparam logic [1:0]  SHAKE256_MODE_VEC = 2'b01;
  localparam int          RATE_SHAKE128     = 1344;
  localparam int          RATE_SHAKE256     = 1088;
  localparam int          CNT_W             = $clog2(RATE_WIDTH / w + 1);
  localparam logic [31:0] W32               = 32'(w);

  typedef enum logic [1:0] {IDLE, WAIT_BLOCK, DUMP} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [1:0]              r_mode;
  logic [31:0]             r_remaining;
  logic [RATE_WIDTH-1:0]   r_piso;
  logic [CNT_W-1:0]        r_word_cnt;
  logic                    r_done;
  logic                    r_squeeze;

  logic [CNT_W-1:0]        w_words_per_block;
  logic                    w_size_zero;
  logic                    w_capture;
  logic                    w_xfer;
  logic                    w_final;
  logic                    w_partial;
  logic                    w_block_end;
  logic [31:0]             w_shift;
  logic [w-1:0]            w_swapped;
  logic [w-1:0]            w_mask;
  logic [w-1:0]            w_word;
  logic                    w_unused;

  // The top nibble of the size is outside the supported range and is dropped.
  assign w_unused    = ^output_size_i[31:28];
  assign w_size_zero = (output_size_i[27:0] == 28'd0);
  assign w_capture   = (r_state == WAIT_BLOCK) && rate_valid_i;
  assign w_xfer      = (r_state == DUMP) && ready_i;
  assign w_final     = (r_remaining <= W32);
  assign w_partial   = (r_remaining < W32);
  assign w_block_end = (r_word_cnt == w_words_per_block - CNT_W'(1));
  assign w_shift     = {r_remaining[31:3], 3'b000};
  assign w_mask      = ~({w{1'b1}} >> w_shift);
  assign w_word      = w_partial ? (w_swapped & w_mask) : w_swapped;

  always_comb begin
    case (r_mode)
      SHAKE128_MODE_VEC: w_words_per_block = CNT_W'(RATE_SHAKE128 / w);
      SHAKE256_MODE_VEC: w_words_per_block = CNT_W'(RATE_SHAKE256 / w);
      default:           w_words_per_block = CNT_W'(RATE_WIDTH / w);
    endcase
  end

  // Lanes are held little-endian internally; the external stream wants byte 0 on top.
  always_comb begin
    w_swapped = '0;
    for (int i = 0; i < w / 8; i++) begin
      w_swapped[8*i +: 8] = r_piso[w-8-8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_i && !w_size_zero) w_next_state = WAIT_BLOCK;
      end
      WAIT_BLOCK: begin
        if (rate_valid_i) w_next_state = DUMP;
      end
      DUMP: begin
        if (w_xfer) begin
          if (w_final)          w_next_state = IDLE;
          else if (w_block_end) w_next_state = WAIT_BLOCK;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    rate_ready_o  = 1'b0;
    valid_o       = 1'b0;
    last_o        = 1'b0;
    data_o        = '0;
    squeeze_req_o = r_squeeze;
    done_o        = r_done;
    unique case (r_state)
      WAIT_BLOCK: rate_ready_o = 1'b1;
      DUMP: begin
        valid_o = 1'b1;
        last_o  = w_final;
        data_o  = w_word;
      end
      default: ;
    endcase
  end

  // Final-word handling takes priority over a block-end squeeze request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= '0;
      r_remaining <= '0;
      r_piso      <= '0;
      r_word_cnt  <= '0;
      r_done      <= 1'b0;
      r_squeeze   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_squeeze <= 1'b0;
      if ((r_state == IDLE) && start_i) begin
        r_mode      <= operation_mode_i;
        r_remaining <= {4'b0000, output_size_i[27:0]};
        r_done      <= w_size_zero;
      end
      if (w_capture) begin
        r_piso     <= rate_input_i;
        r_word_cnt <= '0;
      end
      if (w_xfer) begin
        r_piso      <= r_piso >> w;
        r_word_cnt  <= r_word_cnt + CNT_W'(1);
        r_remaining <= w_final ? 32'd0 : r_remaining - W32;
        r_done      <= w_final;
        r_squeeze   <= !w_final && w_block_end;
      end
    end
  end

endmodule

// File: tb/tb_squeeze_datapath.sv
// Self-checking bench for squeeze_datapath: table-driven operations, randomized operations,
// and a reset-abort sequence, all checked against a word-level reference model.
module tb_squeeze_datapath;

  localparam int         W    = 64;
  localparam int         RW   = 1344;
  localparam logic [1:0] M128 = 2'b00;
  localparam logic [1:0] M256 = 2'b01;
  localparam logic [1:0] MBAD = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [1:0]    operation_mode_i;
  logic [31:0]   output_size_i;
  logic [RW-1:0] rate_input_i;
  logic          rate_valid_i;
  logic          rate_ready_o;
  logic          squeeze_req_o;
  logic [W-1:0]  data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  // Blocks handed to the DUT in capture order; the model reads lanes from here.
  logic [RW-1:0] blocks[$];

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] size;
    int          readyMode;
    bit          laneK;
    int          expWords;
    int          expSqueeze;
  } vec_t;

  always #5 clk = ~clk;

  squeeze_datapath #(.w(W), .RATE_WIDTH(RW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .operation_mode_i (operation_mode_i),
    .output_size_i    (output_size_i),
    .rate_input_i     (rate_input_i),
    .rate_valid_i     (rate_valid_i),
    .rate_ready_o     (rate_ready_o),
    .squeeze_req_o    (squeeze_req_o),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .last_o           (last_o),
    .done_o           (done_o)
  );

   // Single comparison point: every check is counted here and failures reported.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: total words is the bit count rounded up to whole words.
  function automatic int modelWords(input logic [31:0] size);
    int bits = int'(size[27:0]);
    return (bits + 63) / 64;
  endfunction

  function automatic int modelWpb(input logic [1:0] mode);
    return (mode == M256) ? 17 : 21;
  endfunction

  // Word idx of the stream: lane (idx mod wpb) of block (idx div wpb), bytes reversed,
  // keeping only as many leading bytes as are still owed.
  function automatic logic [63:0] modelWord(input logic [31:0] size, input int idx, input logic [1:0] mode);
    int            wpb     = modelWpb(mode);
    int            remBits = int'(size[27:0]) - 64 * idx;
    int            keep    = (remBits >= 64) ? 8 : remBits / 8;
    logic [RW-1:0] blk;
    logic [63:0]   lane;
    logic [63:0]   r = '0;
    if (idx / wpb >= blocks.size()) return '0;
    blk  = blocks[idx / wpb];
    lane = blk[(idx % wpb) * 64 +: 64];
    for (int p = 0; p < 8; p++) begin
      if (p >= 8 - keep) r[p*8 +: 8] = lane[(7 - p) * 8 +: 8];
    end
    return r;
  endfunction

   // Runs one complete operation, supplying blocks on demand and checking every presented word.
  task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] size, input int readyMode,
                               input bit laneK, input int expWords, input int expSqueeze);
    int            nWords    = modelWords(size);
    int            got       = 0;
    int            sq        = 0;
    int            bp        = 0;
    int            cyc       = 0;
    bit            held      = 0;
    bit            finalPrev = 0;
    bit            finished  = 0;
    logic [63:0]   prevData  = '0;
    logic          prevLast  = 1'b0;
    logic [RW-1:0] blk;
    blocks.delete();
    @(negedge clk);
    start_i          = 1'b1;
    operation_mode_i = mode;
    output_size_i    = size;
    @(negedge clk);
    start_i          = 1'b0;
    operation_mode_i = 2'($urandom);
    output_size_i    = $urandom;
    finalPrev        = (nWords == 0);
    while (!finished && cyc < 4000) begin
      if (done_o || finalPrev) begin
        checkOutput("done_o after final word", 64'(done_o), 64'(finalPrev));
        finished = finalPrev;
      end
      finalPrev = 0;
      if (nWords == 0) checkOutput("empty op ready/valid", 64'(rate_ready_o | valid_o), 64'd0);
      if (squeeze_req_o) sq++;
      case (readyMode)
        0:       ready_i = 1'b1;
        1:       ready_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (valid_o && got == 1 && bp < 5) begin
            ready_i = 1'b0;
            bp++;
          end else begin
            ready_i = 1'b1;
          end
        end
      endcase
      if (held) checkOutput("valid held under backpressure", 64'(valid_o), 64'd1);
      if (valid_o) begin
        if (held) begin
          checkOutput("data held under backpressure", data_o, prevData);
          checkOutput("last held under backpressure", 64'(last_o), 64'(prevLast));
        end
        checkOutput($sformatf("word %0d data", got), data_o, modelWord(size, got, mode));
        checkOutput($sformatf("word %0d last", got), 64'(last_o), 64'(got == nWords - 1));
        if (ready_i) begin
          held = 0;
          if (got == nWords - 1) finalPrev = 1;
          got++;
        end else begin
          held     = 1;
          prevData = data_o;
          prevLast = last_o;
        end
      end else begin
        held = 0;
      end
      if (rate_ready_o && $urandom_range(0, 2) != 0) begin
        for (int k = 0; k < RW / 64; k++) blk[k*64 +: 64] = laneK ? 64'(k) : {$urandom, $urandom};
        blocks.push_back(blk);
        rate_input_i = blk;
        rate_valid_i = 1'b1;
      end else begin
        // A stray valid while the block stage is busy must not be captured.
        rate_valid_i = !rate_ready_o && ($urandom_range(0, 7) == 0);
        rate_input_i = {(RW / 32){$urandom}};
      end
      cyc++;
      @(negedge clk);
    end
    checkOutput("operation completed within budget", 64'(finished), 64'd1);
    checkOutput("word count", 64'(got), 64'(expWords));
    checkOutput("squeeze_req pulses", 64'(sq), 64'(expSqueeze));
    ready_i      = 1'b0;
    rate_valid_i = 1'b0;
    checkOutput("quiet after done", 64'({done_o, valid_o, rate_ready_o, squeeze_req_o}), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    rst              = 1'b1;
    start_i          = 1'b0;
    operation_mode_i = '0;
    output_size_i    = '0;
    rate_input_i     = '0;
    rate_valid_i     = 1'b0;
    ready_i          = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset valid_o", 64'(valid_o), 64'd0);
    checkOutput("reset data_o", data_o, 64'd0);
    checkOutput("reset flags", 64'({rate_ready_o, squeeze_req_o, last_o, done_o}), 64'd0);
    rst = 1'b0;

    vecs.push_back('{M128, 32'd256,         0, 1'b1, 4,  0});
    vecs.push_back('{M256, 32'd1152,        1, 1'b0, 18, 1});
    vecs.push_back('{M128, 32'd200,         1, 1'b1, 4,  0});
    vecs.push_back('{M128, 32'd256,         2, 1'b0, 4,  0});
    vecs.push_back('{M128, 32'd0,           0, 1'b0, 0,  0});
    vecs.push_back('{M128, 32'd1344,        1, 1'b0, 21, 0});
    vecs.push_back('{M128, 32'd1408,        1, 1'b0, 22, 1});
    vecs.push_back('{MBAD, 32'd1408,        0, 1'b0, 22, 1});
    vecs.push_back('{M256, 32'd1088,        1, 1'b0, 17, 0});
    vecs.push_back('{M256, 32'd1096,        0, 1'b0, 18, 1});
    vecs.push_back('{M256, 32'd2176,        1, 1'b0, 34, 1});
    vecs.push_back('{M128, 32'd4,           0, 1'b0, 1,  0});
    vecs.push_back('{M128, 32'hF000_0100,   1, 1'b0, 4,  0});
    vecs.push_back('{M128, 32'h1000_0000,   0, 1'b0, 0,  0});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].mode, vecs[i].size, vecs[i].readyMode, vecs[i].laneK,
                    vecs[i].expWords, vecs[i].expSqueeze);
    end

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  m;
      logic [31:0] s;
      int          n;
      m = 2'($urandom_range(0, 3));
      s = 32'($urandom_range(0, 3000)) | ($urandom & 32'hF000_0000);
      n = modelWords(s);
      applyStimulus(m, s, 1, 1'b0, n, (n == 0) ? 0 : (n - 1) / modelWpb(m));
    end

    // Reset in the middle of a dump abandons the output without a done_o pulse.
    @(negedge clk);
    start_i          = 1'b1;
    operation_mode_i = M128;
    output_size_i    = 32'd1344;
    @(negedge clk);
    start_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 10 && !rate_ready_o; c++) @(negedge clk);
    checkOutput("rate_ready before abort", 64'(rate_ready_o), 64'd1);
    rate_input_i = {(RW / 32){$urandom}};
    rate_valid_i = 1'b1;
    @(negedge clk);
    rate_valid_i = 1'b0;
    checkOutput("valid_o before abort", 64'(valid_o), 64'd1);
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b0;
    checkOutput("abort data_o", data_o, 64'd0);
    checkOutput("abort flags", 64'({valid_o, rate_ready_o, squeeze_req_o, last_o, done_o}), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("no done after abort", 64'({done_o, valid_o, rate_ready_o}), 64'd0);
    end
    applyStimulus(M128, 32'd256, 0, 1'b1, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
